multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle RV32I-subset core: lw, sw, R-type, I-type ALU, beq, jal.
//  Sequences a shared instruction/data memory, the IR/PC/ALUOut registers and the register bank
//  over 3-5 cycles per instruction. Waits on a memory ready handshake.
//  Traps on unsupported opcodes and counts retired instructions.
// PARAMETERS
//  TRAP_ON_ILLEGAL  1  1: an illegal opcode enters TRAP and stays there until reset. 0: it returns to FETCH as a NOP.
//  INSTRET_W        32 width of the instret counter
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, synchronous, active-high
//  op           in   7   IR[6:0]
//  funct3       in   3   IR[14:12]
//  funct7_bit5  in   1   IR[30]
//  Zero         in   1   ALU zero flag
//  mem_ready    in   1   memory completes the access this cycle
//  PCWrite      out  1   PC register load enable
//  AdrSrc       out  1   memory address select: 0=PC, 1=Result
//  MemWrite     out  1   memory write strobe
//  IRWrite      out  1   IR and OldPC load enable
//  ResultSrc    out  2   00=ALUOut, 01=Data reg, 10=ALUResult
//  ALUSrcA      out  2   00=PC, 01=OldPC, 10=A reg
//  ALUSrcB      out  2   00=WriteData reg, 01=ImmExt, 10=constant 4
//  ALUControl   out  3   000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc       out  2   00=I, 01=S, 10=B, 11=J
//  RegWrite     out  1   register bank write enable
//  trap         out  1   high while state==TRAP
//  instr_done   out  1   1-cycle pulse when an instruction retires
//  instret      out  INSTRET_W  count of retired instructions; wraps modulo 2^INSTRET_W
//  state        out  4   current state, for debug
// BEHAVIOUR
//  State encoding:
//   FETCH=0  DECODE=1  MEMADR=2  MEMREAD=3  MEMWB=4  MEMWRITE=5
//   EXECR=6  ALUWB=7   EXECI=8   JAL=9      BEQ=10   TRAP=11
//  Reset (rst sampled high at a clock edge):
//   state<=FETCH, instret<=0.
//   While rst is high, PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0.
//   Reset mid-instruction aborts that instruction; it is not counted.
//  Output decode is combinational (Moore on state). Any output not listed for a state is 0.
//  ImmSrc is decoded from op in every state: lw/I-type=00, sw=01, beq=10, jal=11, other=00.
//  State outputs and next state:
//   FETCH:    AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10,
//             PCWrite=mem_ready. Holds in FETCH until mem_ready, then goes to DECODE.
//   DECODE:   ALUSrcA=01, ALUSrcB=01, add (computes the branch target).
//             Next: op 3/35 -> MEMADR; op 51 -> EXECR; op 19 -> EXECI; op 111 -> JAL; op 99 -> BEQ;
//             any other op -> TRAP (TRAP_ON_ILLEGAL=1) or FETCH (TRAP_ON_ILLEGAL=0, not counted).
//   MEMADR:   ALUSrcA=10, ALUSrcB=01, add. Next: op 3 -> MEMREAD, otherwise MEMWRITE.
//   MEMREAD:  AdrSrc=1, ResultSrc=00. Holds until mem_ready, then goes to MEMWB.
//   MEMWB:    ResultSrc=01, RegWrite=1. Goes to FETCH; instr_done=1.
//   MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready.
//             Then goes to FETCH; instr_done=1 in the mem_ready cycle.
//   EXECR:    ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
//   EXECI:    ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
//   JAL:      ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB.
//   ALUWB:    ResultSrc=00, RegWrite=1. Goes to FETCH; instr_done=1.
//   BEQ:      ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero. Goes to FETCH; instr_done=1.
//   TRAP:     all strobes 0, trap=1. Stays in TRAP until rst.
//  ALU decoder, key {ALUOp, funct3, op[5], funct7_bit5}:
//   ALUOp 00 -> add; ALUOp 01 -> sub.
//   ALUOp 10 with funct3=000 -> sub only when op[5]=1 and funct7_bit5=1, otherwise add.
//   ALUOp 10 with funct3=010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
//  instret increments by 1 on every cycle where instr_done=1; all-ones wraps to 0.
//  Cycle counts with mem_ready held at 1: lw=5, sw=4, R/I=4, jal=4, beq=3.
//  Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
// TESTING
//  1. rst held 2 cycles, then addi x8,x0,6 (op 19), mem_ready=1
//     -> states 0,1,8,7,0; RegWrite only in ALUWB; instret=1.
//  2. sub (op 51, funct3 0, funct7_bit5=1)
//     -> ALUControl=001 in EXECR; add (funct7_bit5=0) -> 000.
//  3. lw with mem_ready low 3 cycles in MEMREAD
//     -> MEMREAD held 4 cycles; MEMWB follows; total 8 cycles.
//  4. sw with mem_ready low 2 cycles in MEMWRITE
//     -> MemWrite high 3 cycles; instr_done only in the last; RegWrite never 1.
//  5. beq with Zero=1 -> PCWrite=1 in BEQ; beq with Zero=0 -> PCWrite=0; both 3 cycles.
//  6. op 7'h7F with TRAP_ON_ILLEGAL=1 -> state 11, trap=1 held, instret unchanged; rst -> FETCH.
//     Same op with TRAP_ON_ILLEGAL=0 -> back to FETCH, no strobes asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Control FSM for a multicycle RV32I-subset core (lw, sw,
//                R-type, I-type ALU, beq, jal). Sequences the shared
//                instruction/data memory, IR/PC/ALUOut registers and the
//                register bank over 3-5 cycles per instruction, stalling on
//                the memory ready handshake. Traps on unsupported opcodes
//                and counts retired instructions.
//  Ports       : clk, rst          clock (rising edge), sync active-high reset
//                op, funct3,
//                funct7_bit5       instruction fields from IR
//                Zero              ALU zero flag
//                mem_ready         memory completes the access this cycle
//                PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//                ALUSrcB, ALUControl, ImmSrc, RegWrite
//                                  datapath controls
//                trap              high while parked in TRAP
//                instr_done        one-cycle pulse on retirement
//                instret           retired-instruction counter (wrapping)
//                state             current state, for debug
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int INSTRET_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_bit5,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ALUControl,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic                 trap,
    output logic                 instr_done,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] c_op_lw   = 7'd3;
    localparam logic [6:0] c_op_sw   = 7'd35;
    localparam logic [6:0] c_op_r    = 7'd51;
    localparam logic [6:0] c_op_i    = 7'd19;
    localparam logic [6:0] c_op_jal  = 7'd111;
    localparam logic [6:0] c_op_beq  = 7'd99;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    state_t                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q;

    logic                   w_pc_write;
    logic                   w_mem_write;
    logic                   w_ir_write;
    logic                   w_reg_write;
    logic                   w_done;
    logic [1:0]             w_alu_op;

    // ------------------------------------------------------------------------
    // State and retirement counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and Moore outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        w_pc_write  = 1'b0;
        AdrSrc      = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_done      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        w_alu_op    = 2'b00;

        case (state_q)
            FETCH: begin
                // PC+4 is computed and latched in the same cycle the
                // instruction word arrives.
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Branch target OldPC+imm computed speculatively into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_op_lw, c_op_sw: state_d = MEMADR;
                    c_op_r:           state_d = EXECR;
                    c_op_i:           state_d = EXECI;
                    c_op_jal:         state_d = JAL;
                    c_op_beq:         state_d = BEQ;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = TRAP;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == c_op_lw) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                // Write strobe held until the memory accepts it; the store
                // retires in the accepting cycle.
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_done  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
                state_d  = ALUWB;
            end
            EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
                state_d  = ALUWB;
            end
            JAL: begin
                // Link value PC+4 goes to ALUOut while PC takes the target
                // already sitting in ALUOut from DECODE.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pc_write = 1'b1;
                state_d    = ALUWB;
            end
            ALUWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                state_d     = FETCH;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                w_alu_op   = 2'b01;
                w_pc_write = Zero;
                w_done     = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------------
    always_comb begin
        ALUControl = c_alu_add;
        case (w_alu_op)
            2'b01: ALUControl = c_alu_sub;
            2'b10: begin
                case (funct3)
                    // Only R-type (op[5]=1) distinguishes sub; addi never does.
                    3'b000:  ALUControl = (op[5] && funct7_bit5) ? c_alu_sub : c_alu_add;
                    3'b010:  ALUControl = c_alu_slt;
                    3'b110:  ALUControl = c_alu_or;
                    3'b111:  ALUControl = c_alu_and;
                    default: ALUControl = c_alu_add;
                endcase
            end
            default: ALUControl = c_alu_add;
        endcase
    end

    // ------------------------------------------------------------------------
    // Immediate format, decoded from op in every state
    // ------------------------------------------------------------------------
    always_comb begin
        case (op)
            c_op_sw:  ImmSrc = 2'b01;
            c_op_beq: ImmSrc = 2'b10;
            c_op_jal: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // Architectural strobes are suppressed while reset is asserted so that an
    // aborted instruction cannot write state or retire.
    assign PCWrite    = w_pc_write  & ~rst;
    assign MemWrite   = w_mem_write & ~rst;
    assign IRWrite    = w_ir_write  & ~rst;
    assign RegWrite   = w_reg_write & ~rst;
    assign instr_done = w_done      & ~rst;

    assign trap    = (state_q == TRAP);
    assign instret = instret_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller. Two instances
//                share stimulus: one traps on illegal opcodes (32-bit
//                instret), one treats them as NOPs (4-bit instret, so the
//                counter wraps often). Expected per-cycle behaviour is built
//                per instruction from its class and planned stall counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int K_LW  = 0;
    localparam int K_SW  = 1;
    localparam int K_R   = 2;
    localparam int K_I   = 3;
    localparam int K_JAL = 4;
    localparam int K_BEQ = 5;
    localparam int K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_bit5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic        t_PCWrite, t_AdrSrc, t_MemWrite, t_IRWrite, t_RegWrite;
    logic        t_trap, t_instr_done;
    logic [1:0]  t_ResultSrc, t_ALUSrcA, t_ALUSrcB, t_ImmSrc;
    logic [2:0]  t_ALUControl;
    logic [31:0] t_instret;
    logic [3:0]  t_state;

    logic        n_PCWrite, n_AdrSrc, n_MemWrite, n_IRWrite, n_RegWrite;
    logic        n_trap, n_instr_done;
    logic [1:0]  n_ResultSrc, n_ALUSrcA, n_ALUSrcB, n_ImmSrc;
    logic [2:0]  n_ALUControl;
    logic [3:0]  n_instret;
    logic [3:0]  n_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] retired = '0;

    always #5 clk = ~clk;

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1), .INSTRET_W(32)) u_dut_trap (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_bit5(funct7_bit5),
        .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(t_PCWrite), .AdrSrc(t_AdrSrc), .MemWrite(t_MemWrite), .IRWrite(t_IRWrite),
        .ResultSrc(t_ResultSrc), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB),
        .ALUControl(t_ALUControl), .ImmSrc(t_ImmSrc), .RegWrite(t_RegWrite),
        .trap(t_trap), .instr_done(t_instr_done), .instret(t_instret), .state(t_state)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0), .INSTRET_W(4)) u_dut_nop (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_bit5(funct7_bit5),
        .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(n_PCWrite), .AdrSrc(n_AdrSrc), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite),
        .ResultSrc(n_ResultSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
        .ALUControl(n_ALUControl), .ImmSrc(n_ImmSrc), .RegWrite(n_RegWrite),
        .trap(n_trap), .instr_done(n_instr_done), .instret(n_instret), .state(n_state)
    );

    // One expected clock cycle of the controller.
    typedef struct {
        logic [3:0] st;
        logic [3:0] st_n;
        logic       pcw, adr, mw, irw, rw, done, trp, mr;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
    } cyc_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [3:0] s);
        cyc_t c;
        c.st = s;   c.st_n = s;
        c.pcw = 0;  c.adr = 0; c.mw = 0; c.irw = 0; c.rw = 0; c.done = 0; c.trp = 0;
        c.mr = 1'($urandom_range(0, 1));
        c.rs = 0;   c.sa = 0;  c.sb = 0; c.alu = 3'b000;
        return c;
    endfunction

    function automatic logic [6:0] op_of(input int kind);
        logic [6:0] o;
        case (kind)
            K_LW:    o = 7'd3;
            K_SW:    o = 7'd35;
            K_R:     o = 7'd51;
            K_I:     o = 7'd19;
            K_JAL:   o = 7'd111;
            K_BEQ:   o = 7'd99;
            default: begin
                do o = 7'($urandom);
                while (o == 7'd3 || o == 7'd35 || o == 7'd51 || o == 7'd19 ||
                       o == 7'd111 || o == 7'd99);
            end
        endcase
        return o;
    endfunction

    // Operation implied by the instruction: add/sub, slt(i), or(i), and(i);
    // unsupported funct3 values fall back to add.
    function automatic logic [2:0] alu_exp(input int kind, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (kind == K_R && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [4:0] strobes_t();
        return {t_PCWrite, t_MemWrite, t_IRWrite, t_RegWrite, t_instr_done};
    endfunction

    function automatic logic [4:0] strobes_n();
        return {n_PCWrite, n_MemWrite, n_IRWrite, n_RegWrite, n_instr_done};
    endfunction

    // Holds reset across two rising edges with mem_ready high; called at a
    // falling edge and returns at a falling edge with reset released.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_strobes_t", 64'(strobes_t()), 64'd0);
        check("rst_strobes_n", 64'(strobes_n()), 64'd0);
        @(negedge clk);
        #1;
        check("rst_state_t",   64'(t_state),     64'd0);
        check("rst_state_n",   64'(n_state),     64'd0);
        check("rst_strobes_t", 64'(strobes_t()), 64'd0);
        check("rst_instret_t", 64'(t_instret),   64'd0);
        check("rst_instret_n", 64'(n_instret),   64'd0);
        check("rst_trap_t",    64'(t_trap),      64'd0);
        retired = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one instruction from its FETCH cycle. fst/mst are the number of
    // not-ready cycles in FETCH and in the memory-access state. abort_at >= 0
    // asserts reset in place of that cycle.
    task automatic run_instr(input int kind, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int fst, input int mst,
                             input int abort_at);
        cyc_t       q[$];
        cyc_t       c;
        logic [1:0] imm;
        logic [4:0] exp_strb;

        case (kind)
            K_SW:    imm = 2'b01;
            K_BEQ:   imm = 2'b10;
            K_JAL:   imm = 2'b11;
            default: imm = 2'b00;
        endcase

        for (int i = 0; i <= fst; i++) begin
            c = blank(4'd0);
            c.sb = 2'b10; c.rs = 2'b10;
            c.mr = (i == fst);
            c.irw = c.mr; c.pcw = c.mr;
            q.push_back(c);
        end
        c = blank(4'd1); c.sa = 2'b01; c.sb = 2'b01; q.push_back(c);

        case (kind)
            K_LW, K_SW: begin
                c = blank(4'd2); c.sa = 2'b10; c.sb = 2'b01; q.push_back(c);
                for (int i = 0; i <= mst; i++) begin
                    c = blank(kind == K_LW ? 4'd3 : 4'd5);
                    c.adr = 1'b1;
                    c.mr  = (i == mst);
                    if (kind == K_SW) begin
                        c.mw   = 1'b1;
                        c.done = c.mr;
                    end
                    q.push_back(c);
                end
                if (kind == K_LW) begin
                    c = blank(4'd4); c.rs = 2'b01; c.rw = 1'b1; c.done = 1'b1; q.push_back(c);
                end
            end
            K_R, K_I, K_JAL: begin
                if (kind == K_JAL) begin
                    c = blank(4'd9); c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1;
                end else begin
                    c = blank(kind == K_R ? 4'd6 : 4'd8);
                    c.sa = 2'b10; c.sb = (kind == K_R) ? 2'b00 : 2'b01;
                    c.alu = alu_exp(kind, f3, f7);
                end
                q.push_back(c);
                c = blank(4'd7); c.rw = 1'b1; c.done = 1'b1; q.push_back(c);
            end
            K_BEQ: begin
                c = blank(4'd10); c.sa = 2'b10; c.alu = 3'b001; c.pcw = z; c.done = 1'b1;
                q.push_back(c);
            end
            default: begin
                // Trapping instance parks; the NOP instance sits in FETCH
                // with memory not ready, so it must show no strobes.
                for (int i = 0; i < 3; i++) begin
                    c = blank(4'd11); c.st_n = 4'd0; c.trp = 1'b1; c.mr = 1'b0;
                    q.push_back(c);
                end
            end
        endcase

        op = o; funct3 = f3; funct7_bit5 = f7; Zero = z;
        foreach (q[i]) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            mem_ready = q[i].mr;
            #1;
            exp_strb = {q[i].pcw, q[i].mw, q[i].irw, q[i].rw, q[i].done};
            check("state_t",    64'(t_state),      64'(q[i].st));
            check("strobes_t",  64'(strobes_t()),  64'(exp_strb));
            check("adrsrc_t",   64'(t_AdrSrc),     64'(q[i].adr));
            check("trap_t",     64'(t_trap),       64'(q[i].trp));
            check("resultsrc",  64'(t_ResultSrc),  64'(q[i].rs));
            check("alusrca",    64'(t_ALUSrcA),    64'(q[i].sa));
            check("alusrcb",    64'(t_ALUSrcB),    64'(q[i].sb));
            check("aluctrl",    64'(t_ALUControl), 64'(q[i].alu));
            check("immsrc",     64'(t_ImmSrc),     64'(imm));
            check("instret_t",  64'(t_instret),    64'(retired));
            check("state_n",    64'(n_state),      64'(q[i].st_n));
            check("strobes_n",  64'(strobes_n()),  64'(exp_strb));
            check("trap_n",     64'(n_trap),       64'd0);
            check("instret_n",  64'(n_instret),    64'(retired[3:0]));
            if (q[i].done) retired = retired + 32'd1;
            @(negedge clk);
        end
        if (kind == K_ILL) do_reset();
    endtask

    initial begin
        int kind;
        do_reset();

        // Directed: addi, sub, add, stalled lw/sw, both beq outcomes.
        run_instr(K_I,   7'd19, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        run_instr(K_R,   7'd51, 3'd0, 1'b1, 1'b0, 0, 0, -1);
        run_instr(K_R,   7'd51, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        run_instr(K_LW,  7'd3,  3'd2, 1'b0, 1'b0, 0, 3, -1);
        run_instr(K_SW,  7'd35, 3'd2, 1'b0, 1'b0, 0, 2, -1);
        run_instr(K_BEQ, 7'd99, 3'd0, 1'b0, 1'b1, 0, 0, -1);
        run_instr(K_BEQ, 7'd99, 3'd0, 1'b0, 1'b0, 0, 0, -1);

        // Unbroken legal run so the 4-bit counter wraps.
        for (int i = 0; i < 12; i++) begin
            kind = $urandom_range(0, 5);
            run_instr(kind, op_of(kind), 3'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        // Illegal opcode 7F: trap vs NOP, then reset.
        run_instr(K_ILL, 7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, -1);

        // Randomized mix with occasional illegal opcodes and aborts.
        for (int i = 0; i < 300; i++) begin
            int r;
            int ab;
            r    = $urandom_range(0, 19);
            kind = (r < 18) ? (r % 6) : K_ILL;
            ab   = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(kind, op_of(kind), 3'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4), ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
